// File: rtl/freq_measure.sv
// ---------------------------------------------------------------------------
// freq_measure
//   Gated-count frequency meter. Counts rising edges of an asynchronous input
//   over a window of GATE_CYCLES clk cycles. At the end of each window it
//   publishes the count (edges per window, i.e. Hz with a 1 s gate).
//
// Ports
//   clk     : system clock
//   rstn    : asynchronous active-low reset
//   i_sig   : signal under measurement, asynchronous to clk
//   i_en    : level enable; windows run back-to-back while high
//   o_freq  : last completed count, held between updates
//   o_valid : one-cycle pulse while o_freq/o_ovf hold a freshly completed result
//   o_ovf   : last completed window saturated the edge counter
//   o_busy  : a gate window is open
// ---------------------------------------------------------------------------
module freq_measure #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 28
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_sig,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_freq,
    output logic             o_valid,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LATCH   = 2'd2;

    logic [1:0]       state;
    logic             sync1, sync2, sync3;
    logic             rise;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic             sat;
    logic             sat_nxt;
    logic             gate_last;

    // sync1/sync2 resolve metastability; sync3 is the previous sample for edge detect
    assign rise      = sync2 & ~sync3;
    assign gate_last = (gate_cnt == GATE_LAST);

    // Count including this cycle's edge; saturates instead of wrapping and
    // flags the loss of an edge while sitting at full scale.
    always_comb begin
        edge_nxt = edge_cnt;
        sat_nxt  = sat;
        if (rise) begin
            if (edge_cnt == CNT_MAX) sat_nxt  = 1'b1;
            else                     edge_nxt = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            o_freq   <= '0;
            o_ovf    <= 1'b0;
        end else begin
            sync1 <= i_sig;
            sync2 <= sync1;
            sync3 <= sync2;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (i_en) state <= MEASURE;
                end
                MEASURE: begin
                    if (gate_last) begin
                        // Result registers load on entry to LATCH so they are
                        // already stable during the o_valid cycle. The last
                        // gate cycle completes even if i_en has just dropped.
                        state    <= LATCH;
                        o_freq   <= edge_nxt;
                        o_ovf    <= sat_nxt;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else if (!i_en) begin
                        // abort: partial count dropped, last result kept
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        edge_cnt <= edge_nxt;
                        sat      <= sat_nxt;
                    end
                end
                LATCH: begin
                    // one dead cycle: any edge seen here is not counted
                    state <= i_en ? MEASURE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_valid = (state == LATCH);
    assign o_busy  = (state == MEASURE);

endmodule

// File: tb/tb_freq_measure.sv
module tb_freq_measure;

    localparam int GATE = 1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sig = 1'b0;
    logic        en = 1'b0;
    logic        en_s = 1'b0;
    logic [27:0] freq;
    logic        valid, ovf, busy;
    logic [7:0]  freq_s;
    logic        valid_s, ovf_s, busy_s;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int half = 0;
    int ph = 0;

    typedef struct {
        string tag;
        int    lo;
        int    hi;
        bit    ovf;
    } exp_t;

    exp_t q[$];
    int   vcyc[$];

    freq_measure #(.GATE_CYCLES(GATE), .CNT_W(28)) dut (
        .clk(clk), .rstn(rstn), .i_sig(sig), .i_en(en),
        .o_freq(freq), .o_valid(valid), .o_ovf(ovf), .o_busy(busy)
    );

    freq_measure #(.GATE_CYCLES(GATE), .CNT_W(8)) dut_s (
        .clk(clk), .rstn(rstn), .i_sig(sig), .i_en(en_s),
        .o_freq(freq_s), .o_valid(valid_s), .o_ovf(ovf_s), .o_busy(busy_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // i_sig source: toggles every 'half' clocks, changing on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (half != 0) begin
                ph = ph + 1;
                if (ph >= half) begin
                    ph  = 0;
                    sig = ~sig;
                end
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
        tests++;
        assert (got >= lo && got <= hi) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    // scoreboard: each o_valid pops one expectation
    always @(negedge clk) begin
        if (valid) begin
            vcyc.push_back(cyc);
            if (q.size() == 0) begin
                chk_eq("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk_rng({e.tag, "_freq"}, int'(freq), e.lo, e.hi);
                chk_eq({e.tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic push(input string tag, input int lo, input int hi, input bit o);
        exp_t e;
        e.tag = tag; e.lo = lo; e.hi = hi; e.ovf = o;
        q.push_back(e);
    endtask

    task automatic drain(input string tag, input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk_eq({tag, "_timeout"}, 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_valid_s(input string tag, input int bound, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < bound && !ok) begin
            @(negedge clk);
            if (valid_s) ok = 1'b1;
            n++;
        end
        if (!ok) chk_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int c;
        bit ok;

        // reset held with input toggling
        half = 3;
        repeat (20) @(negedge clk);
        chk_eq("rst_freq", 32'(freq), 32'd0);
        chk_eq("rst_valid", 32'(valid), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_ovf", 32'(ovf), 32'd0);

        // released, disabled: nothing happens
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        chk_eq("idle_busy", 32'(busy), 32'd0);
        chk_eq("idle_freq", 32'(freq), 32'd0);

        // basic count, period 10
        half = 5;
        vcyc.delete();
        push("basic0", 99, 101, 1'b0);
        push("basic1", 99, 101, 1'b0);
        push("basic2", 99, 101, 1'b0);
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("basic_busy", 32'(busy), 32'd1);
        drain("basic", 3500);
        if (vcyc.size() == 3) begin
            chk_eq("basic_gap1", 32'(vcyc[1] - vcyc[0]), 32'(GATE + 1));
            chk_eq("basic_gap2", 32'(vcyc[2] - vcyc[1]), 32'(GATE + 1));
        end else begin
            chk_eq("basic_nvalid", 32'(vcyc.size()), 32'd3);
        end
        en = 1'b0;

        // max rate, toggle every clk
        repeat (5) @(negedge clk);
        half = 1;
        push("maxrate", 499, 501, 1'b0);
        en = 1'b1;
        drain("maxrate", 1200);
        en = 1'b0;

        // abort mid-window
        repeat (10) @(negedge clk);
        half = 5;
        en = 1'b1;
        repeat (501) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("abort_busy", 32'(busy), 32'd0);
        chk_rng("abort_keep_freq", int'(freq), 499, 501);
        repeat (1100) @(negedge clk);
        vcyc.delete();
        push("restart", 99, 101, 1'b0);
        en = 1'b1;
        c = cyc;
        drain("restart", 1200);
        if (vcyc.size() > 0) chk_eq("restart_lat", 32'(vcyc[0] - c), 32'(GATE + 1));
        else chk_eq("restart_nvalid", 32'(vcyc.size()), 32'd1);

        // async reset mid-window (en stays high, window discarded)
        repeat (300) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk_eq("arst_busy", 32'(busy), 32'd0);
        chk_eq("arst_freq", 32'(freq), 32'd0);
        chk_eq("arst_valid", 32'(valid), 32'd0);
        chk_eq("arst_ovf", 32'(ovf), 32'd0);
        #2 rstn = 1'b1;
        c = cyc;
        vcyc.delete();
        push("post_rst", 99, 101, 1'b0);
        drain("post_rst", 1200);
        if (vcyc.size() > 0) chk_eq("post_rst_lat", 32'(vcyc[0] - c), 32'(GATE + 1));
        else chk_eq("post_rst_nvalid", 32'(vcyc.size()), 32'd1);
        en = 1'b0;

        // saturation on the 8-bit instance
        repeat (5) @(negedge clk);
        half = 1;
        en_s = 1'b1;
        wait_valid_s("sat", 1200, ok);
        if (ok) begin
            chk_eq("sat_freq", 32'(freq_s), 32'd255);
            chk_eq("sat_ovf", 32'(ovf_s), 32'd1);
        end
        en_s = 1'b0;
        repeat (5) @(negedge clk);
        half = 50;
        repeat (5) @(negedge clk);
        en_s = 1'b1;
        wait_valid_s("slow", 1200, ok);
        if (ok) begin
            chk_rng("slow_freq", int'(freq_s), 9, 11);
            chk_eq("slow_ovf", 32'(ovf_s), 32'd0);
        end
        en_s = 1'b0;
        repeat (10) @(negedge clk);
        chk_eq("end_queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
